// File: rtl/axo32_muldiv_seq.sv
// Sequential RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide over a shared 64-bit accumulator, with a sign-fixup step before the result.
module axo32_muldiv_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_lhs,
  input  logic [31:0] req_rhs,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_res,
  input  logic        flush,
  output logic [2:0]  dbg_state
);

  // Handshake: a request transfers on an edge with req_valid && req_ready (IDLE only);
  // a response transfers on an edge with resp_valid && resp_ready (DONE only).
  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [63:0] acc_q;
  logic [5:0]  cnt_q;
  logic        neg_res_q, neg_rem_q;
  logic [31:0] res_q;

  logic        lhs_signed, rhs_signed, lhs_neg, rhs_neg;
  logic [31:0] lhs_mag, rhs_mag;
  logic        div_zero, div_ovf, bypass;
  logic [31:0] bypass_res;
  logic [32:0] mul_sum, div_trial;
  logic [63:0] mul_next, div_next;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix, rem_fix, fix_res;

  // Operand conditioning; a_q/b_q still hold raw operands on the first MUL/DIV cycle.
  always_comb begin
    lhs_signed = (op_q == 3'd1) || (op_q == 3'd2) || (op_q == 3'd4) || (op_q == 3'd6);
    rhs_signed = (op_q == 3'd1) || (op_q == 3'd4) || (op_q == 3'd6);
    lhs_neg    = lhs_signed && a_q[31];
    rhs_neg    = rhs_signed && b_q[31];
    lhs_mag    = lhs_neg ? (~a_q + 32'd1) : a_q;
    rhs_mag    = rhs_neg ? (~b_q + 32'd1) : b_q;
    div_zero   = (b_q == 32'd0);
    div_ovf    = rhs_signed && op_q[2] && (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
    bypass     = op_q[2] && (div_zero || div_ovf);
    if (div_zero) bypass_res = op_q[1] ? a_q : 32'hFFFF_FFFF;
    else          bypass_res = op_q[1] ? 32'd0 : 32'h8000_0000;
  end

  // One iteration step of each algorithm; remainder:quotient share acc_q during divide.
  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    mul_next  = {mul_sum, acc_q[31:1]};
    div_trial = {acc_q[63:32], acc_q[31]} - {1'b0, b_q};
    if (!div_trial[32]) div_next = {div_trial[31:0], acc_q[30:0], 1'b1};
    else                div_next = {acc_q[62:0], 1'b0};
  end

  always_comb begin
    prod_fix = neg_res_q ? (~acc_q + 64'd1) : acc_q;
    quot_fix = neg_res_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    rem_fix  = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
    case (op_q)
      3'd0:                fix_res = prod_fix[31:0];
      3'd1, 3'd2, 3'd3:    fix_res = prod_fix[63:32];
      3'd4, 3'd5:          fix_res = quot_fix;
      default:             fix_res = rem_fix;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid) state_d = req_funct3[2] ? DIV : MUL;
      MUL:  if (cnt_q == 6'd32) state_d = FIX;
      DIV: begin
        if (cnt_q == 6'd0 && bypass) state_d = DONE;
        else if (cnt_q == 6'd32)     state_d = FIX;
      end
      FIX:  state_d = DONE;
      DONE: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == DONE);
    resp_res   = res_q;
    dbg_state  = state_q;
  end

  // Datapath: cnt_q == 0 is the magnitude/setup cycle, cnt_q 1..32 are the iterations.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q      <= 3'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      acc_q     <= 64'd0;
      cnt_q     <= 6'd0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      res_q     <= 32'd0;
    end else if (!flush) begin
      case (state_q)
        IDLE: if (req_valid) begin
          op_q  <= req_funct3;
          a_q   <= req_lhs;
          b_q   <= req_rhs;
          cnt_q <= 6'd0;
        end
        MUL, DIV: begin
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd0) begin
            a_q       <= lhs_mag;
            b_q       <= rhs_mag;
            neg_res_q <= lhs_neg ^ rhs_neg;
            neg_rem_q <= lhs_neg;
            acc_q     <= {32'd0, lhs_mag};
            if (state_q == DIV && bypass) res_q <= bypass_res;
          end else begin
            acc_q <= (state_q == MUL) ? mul_next : div_next;
          end
        end
        FIX: res_q <= fix_res;
        default: ;
      endcase
    end
  end

endmodule
